// File: rtl/pe_collect_pkg.sv
// Shared types and helpers for the PE partial-sum collector:
// FSM state encoding, the FIFO pointer-width helper and the signed saturation bounds.
package pe_collect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACC,
    WAIT_ROOM,
    REQ,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  localparam int PSUM_W_DEF     = 48;
  localparam int GLB_W_DEF      = 32;
  localparam int ADDR_W_DEF     = 8;
  localparam int PARA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 36;

  // Bits needed to index 'depth' entries (minimum 1).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Largest value representable in a w-bit two's-complement word.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's-complement word.
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/psum_sync_fifo.sv
// Synchronous FIFO with explicit pointer wrap, so DEPTH need not be a power of two.
// Read data is the registered entry at the read pointer (first-word fall-through).
module psum_sync_fifo
  import pe_collect_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 36,
  parameter int CNT_W = ptr_width(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; only pointers and count define validity, so clearing it would cost a reset net on every bit for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap explicitly at DEPTH-1; count tracks occupancy with simultaneous push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_psum_collector.sv
// Bus-side receiver for the PE partial-sum port: requests a burst once the PE has
// finished accumulating, buffers the words, and writes them to the GLB with
// auto-incrementing addresses. Optional macro PSUM_COLLECT_SAT_EN saturates each
// word to the GLB width before buffering; otherwise words are truncated at the output.
module pe_psum_collector
  import pe_collect_pkg::*;
#(
  parameter int PSUM_DATA_WIDTH = PSUM_W_DEF,
  parameter int GLB_DATA_WIDTH  = GLB_W_DEF,
  parameter int ADDR_WIDTH      = ADDR_W_DEF,
  parameter int PARA_WIDTH      = PARA_W_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [PARA_WIDTH-1:0]      num_psum,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic                       psum_acc_finish,
  output logic                       psum_out_start,
  input  logic [PSUM_DATA_WIDTH-1:0] psum_to_bus,
  input  logic                       psum_out_en,
  output logic [GLB_DATA_WIDTH-1:0]  glb_wdata,
  output logic [ADDR_WIDTH-1:0]      glb_waddr,
  output logic                       glb_wvalid,
  input  logic                       glb_wready,
  output logic                       busy,
  output logic                       collect_done,
  output logic                       err_cfg,
  output logic                       err_unexp
);

`ifdef PSUM_COLLECT_SAT_EN
  localparam int FIFO_W = GLB_DATA_WIDTH;
`else
  localparam int FIFO_W = PSUM_DATA_WIDTH;
`endif
  localparam int CNT_W = ptr_width(FIFO_DEPTH + 1);

  state_t                state;
  logic [PARA_WIDTH-1:0] num_q;
  logic [PARA_WIDTH-1:0] rx_cnt;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  stg_valid;
  logic [FIFO_W-1:0]     stg_data;
  logic [FIFO_W-1:0]     stg_next;
  logic [FIFO_W-1:0]     fifo_rdata;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  start_acc;
  logic                  accept;
  logic                  drop;
  logic                  xfer;
  int                    free_slots;

  // Free entries count the word waiting in the input stage as already occupied.
  assign start_acc  = start && (state == IDLE);
  assign free_slots = FIFO_DEPTH - int'(fifo_count) - int'(stg_valid);
  assign accept     = psum_out_en && (state == COLLECT) && (free_slots > 0) && !fifo_full;
  assign drop       = psum_out_en && !accept;
  assign xfer       = glb_wvalid && glb_wready;

  assign glb_wvalid = !fifo_empty;
  assign glb_waddr  = waddr_q;
  // Forced to zero when empty so the bus never shows stale or uninitialised storage.
  assign glb_wdata  = fifo_empty ? '0 : fifo_rdata[GLB_DATA_WIDTH-1:0];

`ifdef PSUM_COLLECT_SAT_EN
  localparam logic signed [PSUM_DATA_WIDTH-1:0] SAT_HI = PSUM_DATA_WIDTH'(sat_max(GLB_DATA_WIDTH));
  localparam logic signed [PSUM_DATA_WIDTH-1:0] SAT_LO = PSUM_DATA_WIDTH'(sat_min(GLB_DATA_WIDTH));

  // Clamp the signed PE word into the GLB range before it is buffered.
  // NOTE: stg_next gets a default first, so no path through this block can leave it unassigned and infer a latch.
  always_comb begin
    stg_next = psum_to_bus[GLB_DATA_WIDTH-1:0];
    if ($signed(psum_to_bus) > SAT_HI)      stg_next = SAT_HI[GLB_DATA_WIDTH-1:0];
    else if ($signed(psum_to_bus) < SAT_LO) stg_next = SAT_LO[GLB_DATA_WIDTH-1:0];
  end
`else
  assign stg_next = psum_to_bus;

  // Upper psum bits are buffered but dropped by truncation at the output.
  logic unused_fifo_hi;
  assign unused_fifo_hi = ^fifo_rdata[FIFO_W-1:GLB_DATA_WIDTH];
`endif

  // Input stage: registers an accepted strobe, pushed into the FIFO on the next edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_data  <= '0;
    end else begin
      stg_valid <= accept;
      if (accept) stg_data <= stg_next;
    end
  end

  psum_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stg_valid),
    .wdata (stg_data),
    .pop   (xfer),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write address: loads base on an accepted start, then advances per completed transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            waddr_q <= '0;
    else if (start_acc) waddr_q <= base_addr;
    else if (xfer)      waddr_q <= waddr_q + ADDR_WIDTH'(1);
  end

  // Unexpected-strobe flag: sticky until the next accepted start; a new drop wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_unexp <= 1'b0;
    else     err_unexp <= drop || (err_unexp && !start_acc);
  end

  // Control FSM with registered busy, request and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      num_q          <= '0;
      rx_cnt         <= '0;
      busy           <= 1'b0;
      psum_out_start <= 1'b0;
      collect_done   <= 1'b0;
      err_cfg        <= 1'b0;
    end else begin
      psum_out_start <= 1'b0;
      collect_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_q   <= num_psum;
            rx_cnt  <= '0;
            err_cfg <= 1'b0;
            busy    <= 1'b1;
            if (num_psum == '0) begin
              state        <= DONE;
              collect_done <= 1'b1;
            end else if (int'(num_psum) > FIFO_DEPTH) begin
              err_cfg      <= 1'b1;
              state        <= DONE;
              collect_done <= 1'b1;
            end else begin
              state <= WAIT_ACC;
            end
          end
        end
        WAIT_ACC: if (psum_acc_finish) state <= WAIT_ROOM;
        WAIT_ROOM: begin
          if (free_slots >= int'(num_q)) begin
            state          <= REQ;
            psum_out_start <= 1'b1;
          end
        end
        REQ: state <= COLLECT;
        COLLECT: begin
          if (accept) begin
            rx_cnt <= rx_cnt + PARA_WIDTH'(1);
            if (rx_cnt == num_q - PARA_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stg_valid && fifo_empty) begin
            state        <= DONE;
            collect_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_psum_collector.sv
// Directed self-checking bench for pe_psum_collector (default widths/depth).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pe_psum_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_psum = '0;
  logic [7:0]  base_addr = '0;
  logic        psum_acc_finish = 1'b0;
  logic        psum_out_start;
  logic [47:0] psum_to_bus = '0;
  logic        psum_out_en = 1'b0;
  logic [31:0] glb_wdata;
  logic [7:0]  glb_waddr;
  logic        glb_wvalid;
  logic        glb_wready = 1'b1;
  logic        busy;
  logic        collect_done;
  logic        err_cfg;
  logic        err_unexp;

  int n_checks = 0;
  int n_errors = 0;

  pe_psum_collector dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_psum        (num_psum),
    .base_addr       (base_addr),
    .psum_acc_finish (psum_acc_finish),
    .psum_out_start  (psum_out_start),
    .psum_to_bus     (psum_to_bus),
    .psum_out_en     (psum_out_en),
    .glb_wdata       (glb_wdata),
    .glb_waddr       (glb_waddr),
    .glb_wvalid      (glb_wvalid),
    .glb_wready      (glb_wready),
    .busy            (busy),
    .collect_done    (collect_done),
    .err_cfg         (err_cfg),
    .err_unexp       (err_unexp)
  );

  always #5 clk = ~clk;

  // Bus monitor: logs every completed GLB write and counts control pulses.
  int          n_req = 0;
  int          n_done = 0;
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  always @(posedge clk) begin
    if (!rst) begin
      if (glb_wvalid && glb_wready) begin
        wr_addr_q.push_back(glb_waddr);
        wr_data_q.push_back(glb_wdata);
      end
      if (psum_out_start) n_req++;
      if (collect_done)   n_done++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] n, input logic [7:0] b);
    start = 1'b1; num_psum = n; base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [47:0] d, input int gap);
    psum_out_en = 1'b1; psum_to_bus = d;
    tick();
    psum_out_en = 1'b0;
    repeat (gap) tick();
  endtask

  // Returns on the falling edge where psum_out_start is seen (bounded).
  task automatic wait_req(input string tag);
    int k = 0;
    while (psum_out_start !== 1'b1 && k < 50) begin tick(); k++; end
    check(tag, {63'd0, psum_out_start}, 64'd1);
  endtask

  // Returns on the falling edge where collect_done is seen (bounded).
  task automatic wait_done(input string tag);
    int k = 0;
    while (collect_done !== 1'b1 && k < 100) begin tick(); k++; end
    check(tag, {63'd0, collect_done}, 64'd1);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [7:0] a, input logic [31:0] d);
    logic [7:0]  oa = 'x;
    logic [31:0] od = 'x;
    if (idx < wr_addr_q.size()) begin oa = wr_addr_q[idx]; od = wr_data_q[idx]; end
    check({tag, "_addr"}, oa, a);
    check({tag, "_data"}, od, d);
  endtask

  int          base_wr;
  int          req0;
  int          done0;
  logic        stable;
  logic [31:0] exp_big;
  logic [31:0] exp_neg;

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_busy",   busy, 0);
    check("rst_wvalid", glb_wvalid, 0);
    check("rst_wdata",  glb_wdata, 0);
    check("rst_waddr",  glb_waddr, 0);
    check("rst_req",    psum_out_start, 0);
    check("rst_done",   collect_done, 0);
    check("rst_errs",   {err_cfg, err_unexp}, 0);
    rst = 1'b0;
    tick();

    // ---------------- basic burst ----------------
    base_wr = wr_addr_q.size(); req0 = n_req; done0 = n_done;
    do_start(8'd3, 8'h10);
    check("b_busy", busy, 1);
    repeat (5) tick();
    psum_acc_finish = 1'b1;
    wait_req("b_req_seen");
    tick();
    psum_out_en = 1'b1; psum_to_bus = 48'd1;
    tick();
    psum_out_en = 1'b0;
    check("b_lat_t", glb_wvalid, 0);
    tick();
    check("b_lat_t1_valid", glb_wvalid, 1);
    check("b_lat_t1_data",  glb_wdata, 1);
    check("b_lat_t1_addr",  glb_waddr, 8'h10);
    send_word(48'd2, 1);
    send_word(48'd3, 0);
    wait_done("b_done_seen");
    check("b_busy_at_done", busy, 1);
    tick();
    check("b_busy_after", busy, 0);
    psum_acc_finish = 1'b0;
    tick();
    check("b_nreq",  n_req - req0, 1);
    check("b_ndone", n_done - done0, 1);
    check("b_nwr",   wr_addr_q.size() - base_wr, 3);
    check_write("b_w0", base_wr + 0, 8'h10, 32'd1);
    check_write("b_w1", base_wr + 1, 8'h11, 32'd2);
    check_write("b_w2", base_wr + 2, 8'h12, 32'd3);

    // ---------------- backpressure ----------------
    base_wr = wr_addr_q.size(); done0 = n_done;
    glb_wready = 1'b0;
    do_start(8'd3, 8'h20);
    psum_acc_finish = 1'b1;
    wait_req("bp_req_seen");
    tick();
    send_word(48'd1, 0);
    send_word(48'd2, 0);
    send_word(48'd3, 0);
    tick();
    check("bp_valid", glb_wvalid, 1);
    check("bp_data",  glb_wdata, 1);
    check("bp_addr",  glb_waddr, 8'h20);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      stable &= (glb_wdata === 32'd1) && (glb_waddr === 8'h20) && (glb_wvalid === 1'b1);
    end
    check("bp_stable", stable, 1);
    check("bp_busy",   busy, 1);
    check("bp_no_done", n_done - done0, 0);
    glb_wready = 1'b1;
    wait_done("bp_done_seen");
    check("bp_nwr_at_done", wr_addr_q.size() - base_wr, 3);
    check_write("bp_w0", base_wr + 0, 8'h20, 32'd1);
    check_write("bp_w1", base_wr + 1, 8'h21, 32'd2);
    check_write("bp_w2", base_wr + 2, 8'h22, 32'd3);
    psum_acc_finish = 1'b0;
    tick();

    // ---------------- num_psum = 0 ----------------
    req0 = n_req; done0 = n_done;
    do_start(8'd0, 8'h50);
    tick(); tick();
    check("z_ndone", n_done - done0, 1);
    check("z_nreq",  n_req - req0, 0);
    check("z_busy",  busy, 0);
    check("z_errcfg", err_cfg, 0);

    // ---------------- num_psum > FIFO_DEPTH ----------------
    req0 = n_req; done0 = n_done;
    do_start(8'd37, 8'h00);
    check("cfg_err_set", err_cfg, 1);
    repeat (3) tick();
    check("cfg_ndone", n_done - done0, 1);
    check("cfg_nreq",  n_req - req0, 0);
    check("cfg_sticky", err_cfg, 1);

    // ---------------- strobe during WAIT_ACC ----------------
    base_wr = wr_addr_q.size();
    do_start(8'd2, 8'h40);
    check("pe_errcfg_clr", err_cfg, 0);
    send_word(48'h55, 0);
    tick();
    check("pe_unexp", err_unexp, 1);
    check("pe_dropped", glb_wvalid, 0);
    psum_acc_finish = 1'b1;
    wait_req("pe_req_seen");
    tick();
    send_word(48'd7, 0);
    send_word(48'd8, 0);
    wait_done("pe_done_seen");
    check("pe_nwr", wr_addr_q.size() - base_wr, 2);
    check_write("pe_w0", base_wr + 0, 8'h40, 32'd7);
    check_write("pe_w1", base_wr + 1, 8'h41, 32'd8);
    check("pe_unexp_sticky", err_unexp, 1);
    psum_acc_finish = 1'b0;
    tick();

    // ---------------- address wrap ----------------
    base_wr = wr_addr_q.size();
    do_start(8'd4, 8'hFE);
    check("w_unexp_clr", err_unexp, 0);
    psum_acc_finish = 1'b1;
    wait_req("w_req_seen");
    tick();
    send_word(48'hA, 0);
    send_word(48'hB, 2);
    send_word(48'hC, 0);
    send_word(48'hD, 1);
    wait_done("w_done_seen");
    check_write("w_w0", base_wr + 0, 8'hFE, 32'hA);
    check_write("w_w1", base_wr + 1, 8'hFF, 32'hB);
    check_write("w_w2", base_wr + 2, 8'h00, 32'hC);
    check_write("w_w3", base_wr + 3, 8'h01, 32'hD);
    psum_acc_finish = 1'b0;
    tick();

    // ---------------- reset mid-collect ----------------
    done0 = n_done;
    glb_wready = 1'b0;
    do_start(8'd4, 8'h60);
    psum_acc_finish = 1'b1;
    wait_req("r_req_seen");
    tick();
    send_word(48'h11, 0);
    send_word(48'h22, 0);
    check("r_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("r_busy",   busy, 0);
    check("r_wvalid", glb_wvalid, 0);
    check("r_wdata",  glb_wdata, 0);
    check("r_waddr",  glb_waddr, 0);
    check("r_req",    psum_out_start, 0);
    check("r_done",   collect_done, 0);
    check("r_errs",   {err_cfg, err_unexp}, 0);
    psum_acc_finish = 1'b0;
    glb_wready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("r_no_done", n_done - done0, 0);
    check("r_idle_valid", glb_wvalid, 0);

    // ---------------- width conversion ----------------
`ifdef PSUM_COLLECT_SAT_EN
    exp_big = 32'h7FFF_FFFF;
`else
    exp_big = 32'h0000_0000;
`endif
    exp_neg = 32'hFFFF_FFFB;
    base_wr = wr_addr_q.size();
    do_start(8'd2, 8'h30);
    psum_acc_finish = 1'b1;
    wait_req("s_req_seen");
    tick();
    send_word(48'h0100_0000_0000, 1);
    send_word(48'hFFFF_FFFF_FFFB, 0);
    wait_done("s_done_seen");
    check_write("s_big", base_wr + 0, 8'h30, exp_big);
    check_write("s_neg", base_wr + 1, 8'h31, exp_neg);
    psum_acc_finish = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
